pad_scanner: RTL and testbench

- Parametrised successor to the single-pad serial game-controller reader.
- Drives shared latch (sample) and clock (poll) lines to NUM_PADS shift-register pads and shifts NUM_BUTTONS bits from each pad's data line in parallel.
- Publishes a registered button word with per-pad change flags.
- Scans run on a manual trigger or on an internal periodic timer; results feed the UART reporting path.

---
 rtl/pad_scanner.sv | 117 +++++++++++
 tb/tb_pad_scanner.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_scanner.sv
// Multi-pad serial controller reader: latches NUM_PADS shift-register pads, clocks out
// NUM_BUTTONS bits from each in parallel and publishes a registered button word with change flags.
module pad_scanner #(
  parameter int NUM_PADS        = 2,
  parameter int NUM_BUTTONS     = 8,
  parameter int CLK_DIV         = 60,
  parameter int SCAN_INTERVAL   = 166667,
  parameter int ACTIVE_LOW_DATA = 1
) (
  input  logic                            SYSCLK,
  input  logic                            SYSRESET,
  input  logic [NUM_PADS-1:0]             data,
  input  logic                            start,
  input  logic                            auto_en,
  output logic                            sample,
  output logic                            poll,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] buttonData,
  output logic [NUM_PADS-1:0]             changed,
  output logic                            ready,
  output logic                            busy
);

  localparam int TICK_W = $clog2(2*CLK_DIV + 1);
  localparam int IDX_W  = $clog2(NUM_BUTTONS + 1);
  localparam int INT_W  = $clog2(SCAN_INTERVAL + 1);
  localparam bit INVERT = (ACTIVE_LOW_DATA != 0);

  typedef enum logic [2:0] {IDLE, LATCH, BIT_LO, BIT_HI, DONE} state_t;

  state_t                            state, nextState;
  logic [TICK_W-1:0]                 tick;
  logic                              tickEnd;
  logic [IDX_W-1:0]                  idx;
  logic [INT_W-1:0]                  interval;
  logic                              pending;
  logic                              trigger;
  logic [NUM_PADS*NUM_BUTTONS-1:0]   shreg;

  // The latch phase lasts two ticks; every other timed state lasts one.
  always_comb begin
    trigger   = start | pending;
    tickEnd   = (state == LATCH) ? (tick == TICK_W'(2*CLK_DIV - 1))
                                 : (tick == TICK_W'(CLK_DIV - 1));
    nextState = state;
    case (state)
      IDLE:    if (trigger) nextState = LATCH;
      LATCH:   if (tickEnd) nextState = BIT_LO;
      BIT_LO:  if (tickEnd) nextState = BIT_HI;
      BIT_HI:  if (tickEnd) nextState = (idx == IDX_W'(NUM_BUTTONS - 1)) ? DONE : BIT_LO;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      state <= IDLE;
      tick  <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE || state == DONE || tickEnd)
        tick <= '0;
      else
        tick <= tick + 1'b1;
      if (state == LATCH)
        idx <= '0;
      else if (state == BIT_HI && tickEnd)
        idx <= idx + 1'b1;
      if (state == BIT_LO && tickEnd)
        for (int p = 0; p < NUM_PADS; p++)
          shreg[p*NUM_BUTTONS + int'(idx)] <= data[p] ^ INVERT;
    end
  end

  // Pad-facing strobes are registered from the state, so they trail it by one cycle.
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      sample     <= 1'b0;
      poll       <= 1'b0;
      busy       <= 1'b0;
      ready      <= 1'b0;
      buttonData <= '0;
      changed    <= '0;
    end else begin
      sample <= (state == LATCH);
      poll   <= (state == BIT_HI);
      busy   <= (nextState != IDLE);
      ready  <= (state == DONE);
      if (state == DONE) begin
        buttonData <= shreg;
        for (int p = 0; p < NUM_PADS; p++)
          changed[p] <= (buttonData[p*NUM_BUTTONS +: NUM_BUTTONS] !=
                         shreg[p*NUM_BUTTONS +: NUM_BUTTONS]);
      end
    end
  end

  // A scan start swallows any request pending in the same cycle, even one raised on that edge.
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET || !auto_en) begin
      interval <= '0;
      pending  <= 1'b0;
    end else begin
      if (interval == '0)
        interval <= INT_W'(SCAN_INTERVAL - 1);
      else
        interval <= interval - 1'b1;
      if (state == IDLE && trigger)
        pending <= 1'b0;
      else if (interval == '0)
        pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pad_scanner.sv
// Bench for pad_scanner: behavioural shift-register pads plus a scan-level scoreboard
// checking timing, button words and change flags.
module tb_pad_scanner;

  localparam int NB = 8;

  logic        SYSCLK = 1'b0;
  logic        SYSRESET = 1'b1;
  logic [1:0]  data;
  logic        start = 1'b0;
  logic        auto_en = 1'b0;
  logic        sample, poll;
  logic [15:0] buttonData;
  logic [1:0]  changed;
  logic        ready, busy;

  pad_scanner #(
    .NUM_PADS(2), .NUM_BUTTONS(8), .CLK_DIV(4), .SCAN_INTERVAL(200), .ACTIVE_LOW_DATA(1)
  ) dut (
    .SYSCLK(SYSCLK), .SYSRESET(SYSRESET), .data(data), .start(start), .auto_en(auto_en),
    .sample(sample), .poll(poll), .buttonData(buttonData), .changed(changed),
    .ready(ready), .busy(busy)
  );

  always #5 SYSCLK = ~SYSCLK;

  // Pad model: latch reloads the read position, each poll rising edge advances it;
  // a pressed button drives the line low, and past the last button the line idles high.
  logic [7:0] pressed [2] = '{8'h00, 8'h00};
  int         pos [2]     = '{8, 8};

  always @(posedge sample or posedge poll) begin
    for (int p = 0; p < 2; p++)
      if (sample) pos[p] = 0;
      else        pos[p] = pos[p] + 1;
  end

  always_comb begin
    for (int p = 0; p < 2; p++)
      data[p] = (pos[p] < NB) ? ~pressed[p][pos[p][2:0]] : 1'b1;
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-scan observations gathered by applyStimulus
  int firstReady, readyCount, sampleCyc, sampleFirst, pollRises, pollHigh;
  int busyAtStart, busyAfter, readyWord, readyChg, midWord;
  logic [15:0] prevWord = 16'h0000;

  task automatic applyStimulus(input int extraAt);
    logic prevPoll;
    firstReady = -1; readyCount = 0; sampleCyc = 0; sampleFirst = -1;
    pollRises = 0; pollHigh = 0; busyAtStart = -1; busyAfter = -1;
    readyWord = -1; readyChg = -1; midWord = -1; prevPoll = 1'b0;
    @(negedge SYSCLK);
    start = 1'b1;
    @(posedge SYSCLK);
    for (int n = 1; n <= 160; n++) begin
      @(negedge SYSCLK);
      if (n == 1) begin
        start = 1'b0;
        busyAtStart = int'(busy);
      end
      if (n == extraAt) start = 1'b1;
      else if (extraAt > 0 && n == extraAt + 1) start = 1'b0;
      if (sample) begin
        sampleCyc++;
        if (sampleFirst < 0) sampleFirst = n;
      end
      if (poll) pollHigh++;
      if (poll && !prevPoll) pollRises++;
      prevPoll = poll;
      if (n == 40) midWord = int'(buttonData);
      if (firstReady > 0 && n == firstReady + 1) busyAfter = int'(busy);
      if (ready) begin
        readyCount++;
        if (firstReady < 0) begin
          firstReady = n;
          readyWord  = int'(buttonData);
          readyChg   = int'(changed);
        end
      end
    end
  endtask

  // Compare one scan against the scoreboard, then advance the scoreboard's previous word.
  task automatic checkScan(input string tag, input logic [15:0] expWord, input logic [1:0] expChg);
    checkOutput({tag, " latency"},     firstReady - 1, 73);
    checkOutput({tag, " readyCount"},  readyCount, 1);
    checkOutput({tag, " buttonData"},  readyWord, int'(expWord));
    checkOutput({tag, " changed"},     readyChg, int'(expChg));
    checkOutput({tag, " sampleFirst"}, sampleFirst, 2);
    checkOutput({tag, " sampleCyc"},   sampleCyc, 8);
    checkOutput({tag, " pollRises"},   pollRises, 8);
    checkOutput({tag, " pollHigh"},    pollHigh, 32);
    checkOutput({tag, " busyStart"},   busyAtStart, 1);
    checkOutput({tag, " busyAfter"},   busyAfter, 0);
    checkOutput({tag, " holdMid"},     midWord, int'(prevWord));
    prevWord = expWord;
  endtask

  typedef struct {
    logic [7:0]  p0;
    logic [7:0]  p1;
    logic [15:0] expWord;
    logic [1:0]  expChg;
    int          extraAt;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int times [3];
    int nr, cnt, busyCnt;
    logic [15:0] w;
    logic [1:0]  c;

    vecs[0] = '{8'hA5, 8'h00, 16'h00A5, 2'b01, 0};
    vecs[1] = '{8'hA5, 8'h00, 16'h00A5, 2'b00, 0};
    vecs[2] = '{8'hA5, 8'h81, 16'h81A5, 2'b10, 0};
    vecs[3] = '{8'hA5, 8'h81, 16'h81A5, 2'b00, 30};
    vecs[4] = '{8'h00, 8'h81, 16'h8100, 2'b01, 0};
    vecs[5] = '{8'hFF, 8'hFF, 16'hFFFF, 2'b11, 0};

    // Reset held with start asserted and data lines idle high
    start = 1'b1;
    repeat (3) @(posedge SYSCLK);
    @(negedge SYSCLK);
    checkOutput("rst sample",     int'(sample), 0);
    checkOutput("rst poll",       int'(poll), 0);
    checkOutput("rst ready",      int'(ready), 0);
    checkOutput("rst busy",       int'(busy), 0);
    checkOutput("rst changed",    int'(changed), 0);
    checkOutput("rst buttonData", int'(buttonData), 0);
    SYSRESET = 1'b0;
    start    = 1'b0;
    busyCnt  = 0;
    repeat (6) begin
      @(negedge SYSCLK);
      if (busy) busyCnt++;
    end
    checkOutput("rst busyIdle", busyCnt, 0);

    for (int i = 0; i < 6; i++) begin
      pressed[0] = vecs[i].p0;
      pressed[1] = vecs[i].p1;
      applyStimulus(vecs[i].extraAt);
      checkScan($sformatf("vec%0d", i), vecs[i].expWord, vecs[i].expChg);
    end

    for (int i = 0; i < 6; i++) begin
      pressed[0] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) pressed[1] = 8'($urandom_range(0, 255));
      w = {pressed[1], pressed[0]};
      c = {w[15:8] != prevWord[15:8], w[7:0] != prevWord[7:0]};
      applyStimulus(0);
      checkScan($sformatf("rand%0d", i), w, c);
    end

    // Periodic scans: ready pulses one interval apart, none after auto_en drops
    pressed[0] = 8'h3C;
    pressed[1] = 8'hC3;
    @(negedge SYSCLK);
    auto_en = 1'b1;
    nr = 0;
    for (int n = 1; n <= 800 && nr < 3; n++) begin
      @(negedge SYSCLK);
      if (ready) begin
        times[nr] = n;
        nr++;
        if (nr == 3) auto_en = 1'b0;
      end
    end
    checkOutput("auto count", nr, 3);
    if (nr == 3) begin
      checkOutput("auto period1", times[1] - times[0], 200);
      checkOutput("auto period2", times[2] - times[1], 200);
    end
    checkOutput("auto buttonData", int'(buttonData), 16'hC33C);
    prevWord = 16'hC33C;
    cnt = 0;
    repeat (400) begin
      @(negedge SYSCLK);
      if (ready || busy) cnt++;
    end
    checkOutput("auto off", cnt, 0);

    // Manual start on the same edge as a timer expiry yields one scan
    auto_en = 1'b1;
    nr = 0;
    for (int n = 1; n <= 300 && nr == 0; n++) begin
      @(negedge SYSCLK);
      if (ready) nr++;
    end
    checkOutput("coinc firstReady", nr, 1);
    repeat (125) @(negedge SYSCLK);
    start = 1'b1;
    @(negedge SYSCLK);
    start = 1'b0;
    cnt = 0;
    repeat (180) begin
      @(negedge SYSCLK);
      if (ready) cnt++;
    end
    checkOutput("coinc readyCount", cnt, 1);
    auto_en = 1'b0;
    cnt = 0;
    repeat (250) begin
      @(negedge SYSCLK);
      if (ready) cnt++;
    end
    checkOutput("coinc afterOff", cnt, 0);

    // Reset during BIT_LO of bit 3 aborts the scan silently
    pressed[0] = 8'h5A;
    pressed[1] = 8'h3C;
    @(negedge SYSCLK);
    start = 1'b1;
    @(posedge SYSCLK);
    cnt = 0;
    for (int n = 1; n <= 34; n++) begin
      @(negedge SYSCLK);
      if (n == 1) start = 1'b0;
      if (ready) cnt++;
    end
    SYSRESET = 1'b1;
    @(negedge SYSCLK);
    checkOutput("abort sample",     int'(sample), 0);
    checkOutput("abort poll",       int'(poll), 0);
    checkOutput("abort busy",       int'(busy), 0);
    checkOutput("abort buttonData", int'(buttonData), 0);
    SYSRESET = 1'b0;
    repeat (100) begin
      @(negedge SYSCLK);
      if (ready) cnt++;
    end
    checkOutput("abort noReady", cnt, 0);
    prevWord = 16'h0000;
    applyStimulus(0);
    checkScan("afterAbort", 16'h3C5A, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
